dmem_stack_arbiter: RTL and testbench

DMEM_STACK_ARBITER -- requirements
Module: dmem_stack_arbiter

---
 rtl/dmem_stack_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_dmem_stack_arbiter.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_stack_arbiter.sv
// Arbitrates a load/store requester and a stack requester onto one byte-wide
// memory port. Every access moves one 32-bit word over four byte cycles.
// Stack operations keep their own pointer and report overflow/underflow.
module dmem_stack_arbiter #(
  parameter logic [10:0] STACK_EMPTY = 11'd1024,
  parameter logic [10:0] STACK_LIMIT = 11'd512
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_gnt,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  input  logic        st_req,
  input  logic [1:0]  st_op,
  input  logic [31:0] st_wdata,
  output logic        st_gnt,
  output logic        st_done,
  output logic        st_err,
  output logic [31:0] st_rdata,
  output logic [9:0]  mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic [10:0] sp
);

  typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [9:0]  base_q, base_d;
  logic [31:0] data_q, data_d;
  logic        we_q, we_d;
  logic        owner_q, owner_d;      // 1 = stack requester owns the access
  logic        err_q, err_d;
  logic        last_st_q, last_st_d;  // 1 = stack requester was granted last
  logic [10:0] sp_q, sp_d;
  logic [23:0] rbuf_q, rbuf_d;        // read bytes 0..2; byte 3 merges on the final edge
  logic [31:0] ls_rdata_q, ls_rdata_d;
  logic [31:0] st_rdata_q, st_rdata_d;
  logic        ls_gnt_q, ls_gnt_d;
  logic        st_gnt_q, st_gnt_d;
  logic        pick_st;
  logic [10:0] sp_dec;

  // Only the low ten address bits reach the memory.
  logic unused_addr;
  assign unused_addr = ^ls_addr[31:10];

  // State register and all datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= 2'd0;
      base_q     <= 10'd0;
      data_q     <= 32'd0;
      we_q       <= 1'b0;
      owner_q    <= 1'b0;
      err_q      <= 1'b0;
      last_st_q  <= 1'b1;
      sp_q       <= STACK_EMPTY;
      rbuf_q     <= 24'd0;
      ls_rdata_q <= 32'd0;
      st_rdata_q <= 32'd0;
      ls_gnt_q   <= 1'b0;
      st_gnt_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      base_q     <= base_d;
      data_q     <= data_d;
      we_q       <= we_d;
      owner_q    <= owner_d;
      err_q      <= err_d;
      last_st_q  <= last_st_d;
      sp_q       <= sp_d;
      rbuf_q     <= rbuf_d;
      ls_rdata_q <= ls_rdata_d;
      st_rdata_q <= st_rdata_d;
      ls_gnt_q   <= ls_gnt_d;
      st_gnt_q   <= st_gnt_d;
    end
  end

  // Next-state logic: arbitration and stack checks in IDLE, byte sequencing in XFER.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    base_d     = base_q;
    data_d     = data_q;
    we_d       = we_q;
    owner_d    = owner_q;
    err_d      = err_q;
    last_st_d  = last_st_q;
    sp_d       = sp_q;
    rbuf_d     = rbuf_q;
    ls_rdata_d = ls_rdata_q;
    st_rdata_d = st_rdata_q;
    ls_gnt_d   = 1'b0;
    st_gnt_d   = 1'b0;
    sp_dec     = sp_q - 11'd4;
    pick_st    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // On a tie the requester that was not served last wins.
        pick_st = st_req && (!ls_req || !last_st_q);
        if (pick_st) begin
          st_gnt_d  = 1'b1;
          owner_d   = 1'b1;
          last_st_d = 1'b1;
          err_d     = 1'b0;
          cnt_d     = 2'd0;
          state_d   = StXfer;
          if (!st_op[0]) begin
            // PUSH / CALL: pre-decrement, write the word at the new sp.
            if (sp_dec < STACK_LIMIT) begin
              err_d   = 1'b1;
              state_d = StDone;
            end else begin
              sp_d   = sp_dec;
              base_d = sp_dec[9:0];
              we_d   = 1'b1;
              data_d = st_wdata;
            end
          end else begin
            // POP / RET: read at sp, post-increment when the read finishes.
            if (sp_q == STACK_EMPTY) begin
              err_d   = 1'b1;
              state_d = StDone;
            end else begin
              base_d = sp_q[9:0];
              we_d   = 1'b0;
            end
          end
        end else if (ls_req) begin
          ls_gnt_d  = 1'b1;
          owner_d   = 1'b0;
          last_st_d = 1'b0;
          err_d     = 1'b0;
          cnt_d     = 2'd0;
          base_d    = ls_addr[9:0];
          we_d      = ls_we;
          data_d    = ls_wdata;
          state_d   = StXfer;
        end
      end
      StXfer: begin
        cnt_d = cnt_q + 2'd1;
        unique case (cnt_q)
          2'd0: if (!we_q) rbuf_d[7:0]   = mem_rdata;
          2'd1: if (!we_q) rbuf_d[15:8]  = mem_rdata;
          2'd2: if (!we_q) rbuf_d[23:16] = mem_rdata;
          2'd3: begin
            state_d = StDone;
            if (!we_q) begin
              if (owner_q) begin
                st_rdata_d = {mem_rdata, rbuf_q};
                sp_d       = sp_q + 11'd4;
              end else begin
                ls_rdata_d = {mem_rdata, rbuf_q};
              end
            end
          end
          default: ;
        endcase
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Memory port driven purely from registered state.
  assign mem_addr = base_q + {8'd0, cnt_q};
  assign mem_we   = (state_q == StXfer) && we_q;

  // Little-endian byte lane select for writes; zero when not writing.
  always_comb begin
    mem_wdata = 8'h00;
    if (mem_we) begin
      unique case (cnt_q)
        2'd0:    mem_wdata = data_q[7:0];
        2'd1:    mem_wdata = data_q[15:8];
        2'd2:    mem_wdata = data_q[23:16];
        default: mem_wdata = data_q[31:24];
      endcase
    end
  end

  assign ls_gnt   = ls_gnt_q;
  assign st_gnt   = st_gnt_q;
  assign ls_done  = (state_q == StDone) && !owner_q;
  assign st_done  = (state_q == StDone) && owner_q;
  assign st_err   = st_done && err_q;
  assign ls_rdata = ls_rdata_q;
  assign st_rdata = st_rdata_q;
  assign sp       = sp_q;

endmodule

// File: tb/tb_dmem_stack_arbiter.sv
// Self-checking bench for dmem_stack_arbiter: a byte memory on the port and a
// word-level reference model (stack pointer, byte image, expected results).
module tb_dmem_stack_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ls_req, ls_we;
  logic [31:0] ls_addr, ls_wdata;
  logic        ls_gnt, ls_done;
  logic [31:0] ls_rdata;
  logic        st_req;
  logic [1:0]  st_op;
  logic [31:0] st_wdata;
  logic        st_gnt, st_done, st_err;
  logic [31:0] st_rdata;
  logic [9:0]  mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [10:0] sp;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_stack_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ls_req    (ls_req),
    .ls_we     (ls_we),
    .ls_addr   (ls_addr),
    .ls_wdata  (ls_wdata),
    .ls_gnt    (ls_gnt),
    .ls_done   (ls_done),
    .ls_rdata  (ls_rdata),
    .st_req    (st_req),
    .st_op     (st_op),
    .st_wdata  (st_wdata),
    .st_gnt    (st_gnt),
    .st_done   (st_done),
    .st_err    (st_err),
    .st_rdata  (st_rdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .sp        (sp)
  );

  // Byte memory attached to the port; filled with a known pattern first.
  logic [7:0] mem [1024];
  logic       mem_ready = 1'b0;
  assign mem_rdata = mem[mem_addr];

  function automatic logic [7:0] init_byte(input int i);
    return 8'(i * 73 + 29);
  endfunction

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_byte(i);
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  function automatic logic [31:0] mem_word(input int a);
    return {mem[(a + 3) % 1024], mem[(a + 2) % 1024], mem[(a + 1) % 1024], mem[a % 1024]};
  endfunction

  // Reference model state.
  logic [7:0]  ref_mem [1024];
  int          ref_sp;
  bit          ref_last_st;
  logic [31:0] exp_ls_rdata, exp_st_rdata;

  function automatic logic [31:0] ref_word(input int a);
    return {ref_mem[(a + 3) % 1024], ref_mem[(a + 2) % 1024],
            ref_mem[(a + 1) % 1024], ref_mem[a % 1024]};
  endfunction

  task automatic ref_store(input int a, input logic [31:0] d);
    for (int k = 0; k < 4; k++) ref_mem[(a + k) % 1024] = d[8*k +: 8];
  endtask

  // Word-level stack semantics: push below sp, pop at sp, bounded by 512..1024.
  task automatic model_st(input logic [1:0] op, input logic [31:0] d, output bit err);
    err = 1'b0;
    if (!op[0]) begin
      if (ref_sp - 4 < 512) err = 1'b1;
      else begin
        ref_sp -= 4;
        ref_store(ref_sp, d);
      end
    end else begin
      if (ref_sp == 1024) err = 1'b1;
      else begin
        exp_st_rdata = ref_word(ref_sp);
        ref_sp += 4;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ls_req = 1'b0;
    st_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ref_sp = 1024;
    ref_last_st = 1'b1;
    exp_ls_rdata = 32'd0;
    exp_st_rdata = 32'd0;
  endtask

  // Runs one request from IDLE; cycle numbers count negedges after the request is raised.
  task automatic run_xact(input bit is_st, input logic [1:0] op, input logic we,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output int gnt_cyc, output int done_cyc, output int we_cnt,
                          output logic err_seen, output int err_bad);
    if (is_st) begin
      st_req = 1'b1; st_op = op; st_wdata = wd;
    end else begin
      ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wd;
    end
    gnt_cyc = -1; done_cyc = -1; we_cnt = 0; err_seen = 1'b0; err_bad = 0;
    for (int c = 1; c <= 20 && done_cyc < 0; c++) begin
      @(negedge clk);
      if (is_st ? st_gnt : ls_gnt) begin
        gnt_cyc = c;
        ls_req = 1'b0;
        st_req = 1'b0;
      end
      if (mem_we) we_cnt++;
      if (st_err && !st_done) err_bad++;
      if (is_st ? st_done : ls_done) begin
        done_cyc = c;
        err_seen = st_err;
      end
    end
    ls_req = 1'b0;
    st_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (sp !== 11'd1024) begin
      failures++; $display("FAIL reset_sp got=%0d exp=1024", sp);
    end
    checks++;
    if ({ls_gnt, ls_done, st_gnt, st_done, st_err, mem_we} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=000000",
               {ls_gnt, ls_done, st_gnt, st_done, st_err, mem_we});
    end
    checks++;
    if ({mem_addr, mem_wdata} !== 18'd0) begin
      failures++; $display("FAIL reset_mem_port got=%0h/%0h exp=0/0", mem_addr, mem_wdata);
    end
    checks++;
    if ({ls_rdata, st_rdata} !== 64'd0) begin
      failures++; $display("FAIL reset_rdata got=%0h/%0h exp=0/0", ls_rdata, st_rdata);
    end
  endtask

  task automatic test_push_pop();
    int g, dn, wc, eb;
    logic es;
    bit e_err;
    model_st(2'b00, 32'hDEADBEEF, e_err);
    run_xact(1'b1, 2'b00, 1'b0, 32'd0, 32'hDEADBEEF, g, dn, wc, es, eb);
    checks++;
    if (g !== 1 || dn !== 5) begin
      failures++; $display("FAIL push_timing got gnt=%0d done=%0d exp gnt=1 done=5", g, dn);
    end
    checks++;
    if (mem_word(1020) !== 32'hDEADBEEF || wc !== 4) begin
      failures++;
      $display("FAIL push_bytes got=%0h we=%0d exp=deadbeef we=4", mem_word(1020), wc);
    end
    checks++;
    if (sp !== 11'(ref_sp) || es !== 1'b0) begin
      failures++; $display("FAIL push_sp got sp=%0d err=%b exp sp=%0d err=0", sp, es, ref_sp);
    end
    model_st(2'b01, 32'd0, e_err);
    run_xact(1'b1, 2'b01, 1'b0, 32'd0, 32'd0, g, dn, wc, es, eb);
    checks++;
    if (st_rdata !== 32'hDEADBEEF || dn !== 5) begin
      failures++; $display("FAIL pop_data got=%0h done=%0d exp=deadbeef done=5", st_rdata, dn);
    end
    checks++;
    if (sp !== 11'd1024 || wc !== 0 || es !== 1'b0) begin
      failures++; $display("FAIL pop_sp got sp=%0d we=%0d err=%b exp sp=1024 we=0 err=0",
                           sp, wc, es);
    end
  endtask

  task automatic test_underflow();
    int g, dn, wc, eb;
    logic es;
    bit e_err;
    model_st(2'b11, 32'd0, e_err);
    run_xact(1'b1, 2'b11, 1'b0, 32'd0, 32'd0, g, dn, wc, es, eb);
    checks++;
    if (g !== 1 || dn !== 1 || es !== e_err) begin
      failures++;
      $display("FAIL underflow got gnt=%0d done=%0d err=%b exp gnt=1 done=1 err=%b",
               g, dn, es, e_err);
    end
    checks++;
    if (sp !== 11'd1024 || st_rdata !== exp_st_rdata || wc !== 0) begin
      failures++; $display("FAIL underflow_state got sp=%0d rd=%0h we=%0d exp sp=1024 rd=%0h we=0",
                           sp, st_rdata, wc, exp_st_rdata);
    end
  endtask

  task automatic test_random_mix();
    int g, dn, wc, eb;
    logic es;
    bit e_err;
    for (int it = 0; it < 60; it++) begin
      bit          is_st = 1'($urandom_range(0, 1));
      logic [1:0]  op = 2'($urandom_range(0, 3));
      logic        we = 1'($urandom);
      logic [31:0] a = $urandom;
      logic [31:0] d = $urandom;
      int          exp_done, exp_we;
      e_err = 1'b0;
      if (is_st) begin
        model_st(op, d, e_err);
        exp_we = (!e_err && !op[0]) ? 4 : 0;
      end else begin
        if (we) ref_store(int'(a[9:0]), d);
        else exp_ls_rdata = ref_word(int'(a[9:0]));
        exp_we = we ? 4 : 0;
      end
      exp_done = e_err ? 1 : 5;
      run_xact(is_st, op, we, a, d, g, dn, wc, es, eb);
      checks++;
      if (dn !== exp_done || wc !== exp_we || es !== e_err || eb !== 0) begin
        failures++;
        $display("FAIL mix_xact it=%0d st=%0b got done=%0d we=%0d err=%b bad=%0d exp %0d/%0d/%b/0",
                 it, is_st, dn, wc, es, eb, exp_done, exp_we, e_err);
      end
      checks++;
      if (ls_rdata !== exp_ls_rdata || st_rdata !== exp_st_rdata || sp !== 11'(ref_sp)) begin
        failures++;
        $display("FAIL mix_state it=%0d got ls=%0h st=%0h sp=%0d exp ls=%0h st=%0h sp=%0d",
                 it, ls_rdata, st_rdata, sp, exp_ls_rdata, exp_st_rdata, ref_sp);
      end
    end
  endtask

  task automatic test_overflow();
    int g, dn, wc, eb, n, bad;
    logic es;
    bit e_err;
    do_reset();
    n = 0; bad = 0;
    while (ref_sp > 512 && n < 200) begin
      logic [31:0] d = $urandom;
      model_st(2'b10, d, e_err);
      run_xact(1'b1, 2'b10, 1'b0, 32'd0, d, g, dn, wc, es, eb);
      if (es !== 1'b0 || dn !== 5 || wc !== 4) bad++;
      n++;
    end
    checks++;
    if (n !== 128 || bad !== 0 || sp !== 11'd512) begin
      failures++; $display("FAIL fill_stack got pushes=%0d bad=%0d sp=%0d exp 128/0/512", n, bad, sp);
    end
    model_st(2'b00, 32'h12345678, e_err);
    run_xact(1'b1, 2'b00, 1'b0, 32'd0, 32'h12345678, g, dn, wc, es, eb);
    checks++;
    if (es !== 1'b1 || e_err !== 1'b1 || dn !== 1 || wc !== 0 || sp !== 11'd512) begin
      failures++; $display("FAIL overflow got err=%b done=%0d we=%0d sp=%0d exp 1/1/0/512",
                           es, dn, wc, sp);
    end
    for (int i = 0; i < 8; i++) begin
      model_st(2'b11, 32'd0, e_err);
      run_xact(1'b1, 2'b11, 1'b0, 32'd0, 32'd0, g, dn, wc, es, eb);
      checks++;
      if (st_rdata !== exp_st_rdata || sp !== 11'(ref_sp) || es !== 1'b0) begin
        failures++; $display("FAIL ret_after_fill i=%0d got rd=%0h sp=%0d exp rd=%0h sp=%0d",
                             i, st_rdata, sp, exp_st_rdata, ref_sp);
      end
    end
  endtask

  task automatic test_ls_wrap();
    int g, dn, wc, eb;
    logic es;
    logic [31:0] d = $urandom;
    ref_store(10'h3FE, d);
    run_xact(1'b0, 2'b00, 1'b1, 32'h0000_03FE, d, g, dn, wc, es, eb);
    checks++;
    if ({mem[1], mem[0], mem[1023], mem[1022]} !== d || wc !== 4) begin
      failures++; $display("FAIL wrap_store got=%0h we=%0d exp=%0h we=4",
                           {mem[1], mem[0], mem[1023], mem[1022]}, wc, d);
    end
    exp_ls_rdata = ref_word(10'h3FE);
    run_xact(1'b0, 2'b00, 1'b0, 32'hFFFF_FBFE, 32'd0, g, dn, wc, es, eb);
    checks++;
    if (ls_rdata !== d || dn !== 5 || wc !== 0) begin
      failures++; $display("FAIL wrap_load got=%0h done=%0d we=%0d exp=%0h done=5 we=0",
                           ls_rdata, dn, wc, d);
    end
  endtask

  task automatic test_arbitration();
    logic [31:0] a = 32'h0000_0100;
    logic [31:0] dl = $urandom;
    logic [31:0] ds = $urandom;
    int ng = 0, prev = 0;
    bit e_err, exp_st, finished = 1'b0;
    rst_n = 1'b0;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = a; ls_wdata = dl;
    st_req = 1'b1; st_op = 2'b00; st_wdata = ds;
    @(negedge clk);
    rst_n = 1'b1;
    ref_sp = 1024; ref_last_st = 1'b1;
    exp_ls_rdata = 32'd0; exp_st_rdata = 32'd0;
    for (int c = 1; c <= 40 && !finished; c++) begin
      @(negedge clk);
      if (ng == 3 && (ls_done || st_done)) finished = 1'b1;
      if (ls_gnt || st_gnt) begin
        exp_st = !ref_last_st;
        ref_last_st = exp_st;
        if (exp_st) model_st(2'b00, ds, e_err);
        else ref_store(int'(a[9:0]), dl);
        checks++;
        if ({ls_gnt, st_gnt} !== {!exp_st, exp_st}) begin
          failures++; $display("FAIL rr_winner n=%0d got ls/st=%b%b exp=%b%b",
                               ng, ls_gnt, st_gnt, !exp_st, exp_st);
        end
        if (ng > 0) begin
          checks++;
          if (c - prev !== 6) begin
            failures++; $display("FAIL rr_spacing n=%0d got=%0d exp=6", ng, c - prev);
          end
        end
        prev = c;
        ng++;
        if (ng == 3) begin
          ls_req = 1'b0;
          st_req = 1'b0;
        end
      end
    end
    ls_req = 1'b0;
    st_req = 1'b0;
    @(negedge clk);
    checks++;
    if (!finished || mem_word(int'(a[9:0])) !== dl || sp !== 11'(ref_sp)) begin
      failures++; $display("FAIL rr_result got done=%b word=%0h sp=%0d exp done=1 word=%0h sp=%0d",
                           finished, mem_word(int'(a[9:0])), sp, dl, ref_sp);
    end
  endtask

  task automatic test_reset_abort();
    int g, dn, wc, eb, done_seen = 0;
    logic es;
    bit e_err;
    logic [31:0] d = $urandom;
    do_reset();
    st_req = 1'b1; st_op = 2'b00; st_wdata = d;
    @(negedge clk);
    st_req = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (mem_we !== 1'b1 || sp !== 11'd1020) begin
      failures++; $display("FAIL abort_pre got we=%b sp=%0d exp we=1 sp=1020", mem_we, sp);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_we !== 1'b0 || sp !== 11'd1024 || mem_addr !== 10'd0 || st_gnt !== 1'b0) begin
      failures++; $display("FAIL abort_async got we=%b sp=%0d addr=%0d gnt=%b exp 0/1024/0/0",
                           mem_we, sp, mem_addr, st_gnt);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (st_done || ls_done) done_seen++;
      if (c == 1) rst_n = 1'b1;
    end
    ref_sp = 1024;
    exp_ls_rdata = 32'd0; exp_st_rdata = 32'd0;
    ref_mem[1020] = d[7:0];
    ref_mem[1021] = d[15:8];
    checks++;
    if (done_seen !== 0 || mem_word(1020) !== ref_word(1020)) begin
      failures++; $display("FAIL abort_mem got done=%0d word=%0h exp done=0 word=%0h",
                           done_seen, mem_word(1020), ref_word(1020));
    end
    model_st(2'b01, 32'd0, e_err);
    run_xact(1'b1, 2'b01, 1'b0, 32'd0, 32'd0, g, dn, wc, es, eb);
    checks++;
    if (es !== e_err || dn !== 1 || st_rdata !== 32'd0) begin
      failures++; $display("FAIL abort_pop got err=%b done=%0d rd=%0h exp err=%b done=1 rd=0",
                           es, dn, st_rdata, e_err);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = 32'd0; ls_wdata = 32'd0;
    st_req = 1'b0; st_op = 2'b00; st_wdata = 32'd0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_byte(i);
    ref_sp = 1024; ref_last_st = 1'b1;
    exp_ls_rdata = 32'd0; exp_st_rdata = 32'd0;
    @(posedge clk);
    @(negedge clk);
    mem_ready = 1'b1;
    test_reset();
    test_push_pop();
    test_underflow();
    test_random_mix();
    test_overflow();
    test_ls_wrap();
    test_arbitration();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
